// File: rtl/iris_mlp_pkg.sv
// Shared constants, bus layout and loader state encoding for the IRIS MLP parameter path.
package iris_mlp_pkg;

    localparam int unsigned N_WEIGHTS        = 21;
    localparam int unsigned W_BITS           = 8;
    localparam int unsigned N_CFG_BYTES      = 33;
    localparam int unsigned N_BIASES         = 6;
    localparam int unsigned N_NARROW_BIASES  = 3;
    localparam int unsigned NARROW_BIAS_BITS = 12;
    localparam int unsigned WIDE_BIAS_BITS   = 16;
    localparam int unsigned WIDE_BIAS_OFFSET = N_NARROW_BIASES * NARROW_BIAS_BITS;
    localparam int unsigned WEIGHTS_BITS     = N_WEIGHTS * W_BITS;
    localparam int unsigned BIASES_BITS      = WIDE_BIAS_OFFSET
                                             + (N_BIASES - N_NARROW_BIASES) * WIDE_BIAS_BITS;
    localparam int unsigned BIAS_BYTE_BASE   = N_WEIGHTS;
    localparam int unsigned CNT_BITS         = 6;
    localparam int unsigned LAST_IDX         = N_CFG_BYTES - 1;
    localparam int unsigned SHADOW_BYTES     = N_CFG_BYTES - 1;
    localparam int unsigned SHADOW_IDX_BITS  = $clog2(SHADOW_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } load_state_t;

    // LSB position of bias j on the packed bias bus
    function automatic int unsigned bias_lsb(input int unsigned j);
        if (j < N_NARROW_BIASES)
            return j * NARROW_BIAS_BITS;
        return WIDE_BIAS_OFFSET + (j - N_NARROW_BIASES) * WIDE_BIAS_BITS;
    endfunction

endpackage

// File: rtl/iris_param_loader_if.sv
// Byte-wide valid/ready configuration stream into the parameter loader.
interface iris_param_loader_if;
    import iris_mlp_pkg::*;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [W_BITS-1:0] cfg_data;
    logic              cfg_last;

    modport master (output cfg_valid, output cfg_data, output cfg_last, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_data, input  cfg_last, output cfg_ready);

endinterface

// File: rtl/iris_param_loader.sv
// Collects 33-byte parameter frames into shadow registers and commits them
// atomically onto the active weight/bias buses feeding the combinational MLP.
module iris_param_loader
    import iris_mlp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    iris_param_loader_if.slave      cfg,
    output logic [WEIGHTS_BITS-1:0] weights,
    output logic [BIASES_BITS-1:0]  biases,
    output logic                    params_valid,
    output logic                    commit,
    output logic                    frame_err
);

    load_state_t         state;
    load_state_t         state_nxt;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] cnt_nxt;

    logic xfer;
    logic at_last_idx;
    logic ready_q;
    logic commit_nxt;
    logic err_nxt;
    logic shadow_we;

    logic [W_BITS-1:0]       shadow [SHADOW_BYTES];
    logic [W_BITS-1:0]       frame  [N_CFG_BYTES];
    logic [WEIGHTS_BITS-1:0] weights_nxt;
    logic [BIASES_BITS-1:0]  biases_nxt;

    assign cfg.cfg_ready = ready_q;
    assign xfer          = cfg.cfg_valid && ready_q;
    assign at_last_idx   = (cnt == CNT_BITS'(LAST_IDX));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: only accepted bytes move the frame position
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (xfer) begin
            unique case (state)
                ST_IDLE: begin
                    if (!cfg.cfg_last) begin
                        state_nxt = ST_LOAD;
                        cnt_nxt   = CNT_BITS'(1);
                    end
                end
                ST_LOAD: begin
                    if (cfg.cfg_last) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else if (at_last_idx) begin
                        state_nxt = ST_DRAIN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt   = cnt + CNT_BITS'(1);
                    end
                end
                ST_DRAIN: begin
                    if (cfg.cfg_last)
                        state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode: a frame is good only if its last byte lands on index 32
    always_comb begin
        commit_nxt = 1'b0;
        err_nxt    = 1'b0;
        shadow_we  = 1'b0;
        if (xfer) begin
            unique case (state)
                ST_IDLE: begin
                    shadow_we = 1'b1;
                    err_nxt   = cfg.cfg_last;
                end
                ST_LOAD: begin
                    shadow_we  = !at_last_idx;
                    commit_nxt = cfg.cfg_last && at_last_idx;
                    err_nxt    = cfg.cfg_last && !at_last_idx;
                end
                ST_DRAIN: begin
                    err_nxt = cfg.cfg_last;
                end
                default: begin
                    err_nxt = 1'b0;
                end
            endcase
        end
    end

    // Shadow bank holds bytes 0..31; byte 32 is taken straight from the bus at commit
    always_ff @(posedge clk) begin
        if (shadow_we)
            shadow[cnt[SHADOW_IDX_BITS-1:0]] <= cfg.cfg_data;
    end

    for (genvar i = 0; i < SHADOW_BYTES; i++) begin : g_frame
        assign frame[i] = shadow[i];
    end
    assign frame[LAST_IDX] = cfg.cfg_data;

    for (genvar k = 0; k < N_WEIGHTS; k++) begin : g_wpack
        assign weights_nxt[k*W_BITS +: W_BITS] = frame[k];
    end

    // Narrow biases keep only the low nibble of their high byte
    for (genvar j = 0; j < N_NARROW_BIASES; j++) begin : g_bnarrow
        assign biases_nxt[bias_lsb(j) +: NARROW_BIAS_BITS] =
            {frame[BIAS_BYTE_BASE + 2*j + 1][3:0], frame[BIAS_BYTE_BASE + 2*j]};
    end

    for (genvar j = N_NARROW_BIASES; j < N_BIASES; j++) begin : g_bwide
        assign biases_nxt[bias_lsb(j) +: WIDE_BIAS_BITS] =
            {frame[BIAS_BYTE_BASE + 2*j + 1], frame[BIAS_BYTE_BASE + 2*j]};
    end

    // Active bank and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weights      <= '0;
            biases       <= '0;
            params_valid <= 1'b0;
            commit       <= 1'b0;
            frame_err    <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            ready_q   <= 1'b1;
            commit    <= commit_nxt;
            frame_err <= err_nxt;
            if (commit_nxt) begin
                weights      <= weights_nxt;
                biases       <= biases_nxt;
                params_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/iris_param_loader.md
IRIS_PARAM_LOADER -- requirements
Module: iris_param_loader

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; ports in order below.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 cfg_valid  in  1  configuration byte present.
REQ-005 cfg_ready  out  1  loader accepts byte; transfer when cfg_valid && cfg_ready.
REQ-006 cfg_data  in  8  configuration byte.
REQ-007 cfg_last  in  1  marks final byte of a load frame.
REQ-008 weights  out  168  active weight bus, 21 signed 8-bit weights, weight k at [8k+7:8k]; feeds the combinational MLP directly.
REQ-009 biases  out  84  active bias bus: biases 0..2 12-bit at [12j+11:12j]; biases 3..5 16-bit at [36+16(j-3)+15 : 36+16(j-3)].
REQ-010 params_valid  out  1  active buses hold a complete committed frame.
REQ-011 commit  out  1  one-cycle pulse, active buses updated this cycle.
REQ-012 frame_err  out  1  one-cycle pulse on malformed frame.

Function
REQ-013 Frame SHALL be exactly 33 bytes: bytes 0..20 = weights 0..20; bytes 21..32 = biases 0..5, two bytes each, low byte first.
REQ-014 For 12-bit biases the high byte SHALL contribute bits [3:0] only; bits [7:4] ignored.
REQ-015 Bytes SHALL be written into shadow registers; active weights/biases SHALL change only on commit, never mid-frame.
REQ-016 States: IDLE, LOAD, DRAIN; byte counter 6-bit, 0..32.
REQ-017 IDLE: cfg_ready=1; accepted byte is byte 0, go LOAD (counter=1); if that byte also carries cfg_last, frame_err, stay IDLE.
REQ-018 LOAD: cfg_ready=1; each accepted byte increments counter.
REQ-019 Byte 32 accepted with cfg_last=1: next edge copies shadow (incl. byte 32) to active, commit=1, params_valid=1, counter=0, IDLE.
REQ-020 cfg_last on byte index <32: frame_err pulse, shadow discarded, active unchanged, IDLE.
REQ-021 Byte 32 accepted with cfg_last=0: go DRAIN, no commit.
REQ-022 DRAIN: cfg_ready=1, bytes discarded; on accepted cfg_last, frame_err pulse, IDLE.
REQ-023 cfg_valid=0 cycles SHALL NOT advance any state; no timeout.
REQ-024 Reload while params_valid=1 SHALL keep old active values and params_valid=1 until new commit; failed reload leaves them intact.
REQ-025 commit and frame_err SHALL never assert in the same cycle; latency last-byte-accept to commit = 1 cycle.

Reset
REQ-026 During rst_n=0: weights=0, biases=0, params_valid=0, commit=0, frame_err=0, cfg_ready=0, state IDLE, counter 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; first byte after reset is byte 0.
REQ-028 cfg_ready SHALL be 1 in the first cycle after rst_n returns high.

Structure
REQ-029 Shared package iris_mlp_pkg SHALL hold N_WEIGHTS=21, W_BITS=8, N_CFG_BYTES=33, bias widths/offsets, total bus widths (168, 84) and the state enum.
REQ-030 No sub-module; single module with shadow/active register banks.

Verification
REQ-031 Reset, then 33 bytes (weight k = k+1, biases 0x001..0x006 encoded) with last on byte 32 -> commit one cycle after, weights[7:0]=0x01, weights[167:160]=0x15, biases[11:0]=0x001, biases[83:68]=0x0006, params_valid=1.
REQ-032 Same frame with random cfg_valid gaps -> identical active values, single commit pulse.
REQ-033 Committed frame A, then 10-byte frame with last on byte 9 -> frame_err pulse, active still A, params_valid=1.
REQ-034 40-byte frame, last on byte 39 -> no commit, frame_err when byte 39 accepted, active unchanged.
REQ-035 12-bit bias high byte 0xF3 -> stored nibble 3, upper nibble dropped.
REQ-036 rst_n low after byte 15, then full valid frame -> commit with new values only, all outputs zero during reset.
